lif_edge_port: RTL and testbench
================================

# lif_edge_port

Boundary port for the lattice-gas array. One instance sits on each open edge of the `lif` grid and acts as the missing neighbour of a boundary cell. Each cycle it reads that cell's 4-bit state and drives the 4-bit neighbour word the cell consumes. Host-requested particles are injected inward at a programmed minimum spacing. Outward-moving particles are either absorbed and counted, or reflected straight back into the lattice.

## Interface
- `IN_BIT`, 2, bit of `edge_word` that the boundary cell treats as an arriving inward particle.
- `OUT_BIT`, 0, bit of `cell_state` that represents a particle leaving the lattice through this edge.
- `GAP`, 3, minimum idle cycles between successive injections (0..255); injections are spaced GAP+1 cycles.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `cell_state`  input  4  `out` of the adjacent boundary cell.
- `edge_word`  output  4  registered; drives the boundary cell's neighbour input for this edge.
- `mode`  input  1  0 = absorb, 1 = reflect; sampled every cycle.
- `inj_valid`  input  1  host injection request.
- `inj_count`  input  8  number of particles to inject; captured on accept.
- `inj_ready`  output  1  high when `pending` == 0.
- `pending`  output  8  particles still to inject.
- `absorbed`  output  16  saturating count of absorbed particles.
- `absorbed_clr`  input  1  synchronous clear of `absorbed`.

## Operation
- `outbound` = `cell_state[OUT_BIT]`, evaluated combinationally each cycle.
- Registers: `edge_word` (4), `pending` (8), `gap_cnt` (8), `absorbed` (16).
- **Accept:** `inj_valid && inj_ready` → `pending <= inj_count`. A count of 0 is accepted with no effect. Requests while `inj_ready` is low are ignored, not queued.
- **Drive `edge_word`** (all bits other than `IN_BIT` are always 0). Priority order:
  1. Reflect: if `mode` = 1 and `outbound`, set `edge_word[IN_BIT] <= 1`. Does not touch `pending` or `gap_cnt`.
  2. Inject: else if `pending` != 0 and `gap_cnt` == 0, set `edge_word[IN_BIT] <= 1`, `pending <= pending - 1`, `gap_cnt <= GAP`.
  3. Otherwise, `edge_word <= 0`.
- **Gap counter:** when no injection occurs, `gap_cnt` decrements if nonzero, including during reflect-stalled cycles.
- **Absorb:** if `absorbed_clr`, `absorbed <= 0`; clear wins, and an outbound particle in the same cycle is dropped uncounted. Else if `mode` = 0 and `outbound` and `absorbed` != 16'hFFFF, `absorbed <= absorbed + 1`. Saturates at FFFF.
- In reflect mode, outbound particles are never counted.
- Accept and inject cannot happen in the same cycle, because accept requires `pending` == 0.
- A `mode` change takes effect on the next edge; there is no flush.

## Timing
- Reset (asynchronous, immediate): `edge_word` = 0, `pending` = 0, `gap_cnt` = 0, `absorbed` = 0, so `inj_ready` = 1.
- Reset during an injection burst discards the remaining `pending`. `edge_word` goes to 0 immediately, not at the next clock.
- Accept at edge N → first `edge_word[IN_BIT]` = 1 after edge N+1, provided `gap_cnt` is 0 and no reflect occurs.
- Consecutive injections appear after edges N+1, N+1+(GAP+1), and so on. With GAP = 0 they appear back-to-back.
- `inj_ready` rises in the cycle after the edge that injects the last particle. The earliest next accept is that edge; its first injection still waits for `gap_cnt` to reach 0.
- Reflect latency: `outbound` in cycle k → `edge_word[IN_BIT]` = 1 in cycle k+1. This is one hop, matching lattice propagation.
- Absorb latency: `outbound` in cycle k → `absorbed` is incremented as seen in cycle k+1.

## Test plan
- **Reset:** assert `reset` mid-burst (`pending` = 5) → `edge_word` = 0000, `pending` = 0, `inj_ready` = 1, `absorbed` = 0, all without a clock edge.
- **GAP = 0 burst:** accept `inj_count` = 3 at edge N → `edge_word` = 0100 after edges N+1..N+3, then 0000. `inj_ready` is low after edges N..N+2 and high after edge N+3.
- **GAP = 3 spacing:** accept `inj_count` = 2 at edge N → `edge_word` = 0100 after edges N+1 and N+5 only. `pending` sequence is 2, 1, 1, 1, 1, 0.
- **Absorb:** `mode` = 0, `cell_state` = 0001 for 5 separate cycles → `absorbed` = 5, `edge_word` stays 0000. Preload FFFF plus one more outbound → `absorbed` stays FFFF. `absorbed_clr` coincident with outbound → `absorbed` = 0.
- **Reflect:** `mode` = 1, `cell_state` = 0001 in cycle k → `edge_word` = 0100 in cycle k+1 and `absorbed` unchanged.
- **Reflect stalls injection:** same setup with `pending` = 1 and `gap_cnt` = 0 → the injection is deferred to the first cycle without an outbound particle, and `pending` stays 1 until then.

Source files
------------

// File: rtl/lif_edge_port.sv
// ============================================================================
//  Module      : lif_edge_port
//  Description : Open-edge boundary port for the lif lattice-gas array.
//                Stands in for the missing neighbour of a boundary cell:
//                injects host-requested particles inward at a minimum
//                spacing, and absorbs (counts) or reflects outbound ones.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lif_edge_port #(
   parameter int IN_BIT  = 2,   // edge_word bit the cell reads as an arriving particle
   parameter int OUT_BIT = 0,   // cell_state bit that leaves through this edge
   parameter int GAP     = 3    // idle cycles between injections (0..255)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  cell_state,
   output logic [3:0]  edge_word,
   input  logic        mode,
   input  logic        inj_valid,
   input  logic [7:0]  inj_count,
   output logic        inj_ready,
   output logic [7:0]  pending,
   output logic [15:0] absorbed,
   input  logic        absorbed_clr
);

   localparam logic [3:0] IN_MASK   = 4'(1 << IN_BIT);
   localparam logic [7:0] GAP_VAL   = GAP[7:0];
   localparam logic [15:0] ABS_MAX  = 16'hFFFF;

   logic [7:0] gap_cnt;
   logic       outbound;
   logic       reflect;
   logic       inject;
   logic       accept;

   // Particle leaving the lattice through this edge in the current cycle.
   assign outbound  = cell_state[OUT_BIT];

   // Reflection outranks injection; an injection waits for the spacing
   // counter to drain. Accept is only possible with nothing pending, so it
   // can never coincide with an injection.
   assign reflect   = mode && outbound;
   assign inject    = !reflect && (pending != 8'd0) && (gap_cnt == 8'd0);
   assign inj_ready = (pending == 8'd0);
   assign accept    = inj_valid && inj_ready;

   // Neighbour word: only the inward bit is ever set, by a bounce or an injection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edge_word <= 4'd0;
      end else if (reflect || inject) begin
         edge_word <= IN_MASK;
      end else begin
         edge_word <= 4'd0;
      end
   end

   // Burst bookkeeping: load on accept, count down one per injection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= 8'd0;
      end else if (accept) begin
         pending <= inj_count;
      end else if (inject) begin
         pending <= pending - 8'd1;
      end
   end

   // Spacing counter: reloaded on each injection, otherwise drains to zero,
   // including while reflections are stalling the burst.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gap_cnt <= 8'd0;
      end else if (inject) begin
         gap_cnt <= GAP_VAL;
      end else if (gap_cnt != 8'd0) begin
         gap_cnt <= gap_cnt - 8'd1;
      end
   end

   // Saturating absorb counter; a clear drops any coincident outbound particle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         absorbed <= 16'd0;
      end else if (absorbed_clr) begin
         absorbed <= 16'd0;
      end else if (!mode && outbound && (absorbed != ABS_MAX)) begin
         absorbed <= absorbed + 16'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lif_edge_port.sv
// ============================================================================
//  Module      : tb_lif_edge_port
//  Description : Self-checking bench for lif_edge_port (GAP=3 and GAP=0).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lif_edge_port;

   logic        clk;
   logic        reset;

   // Main instance, GAP = 3
   logic [3:0]  cell_state;
   logic [3:0]  edge_word;
   logic        mode;
   logic        inj_valid;
   logic [7:0]  inj_count;
   logic        inj_ready;
   logic [7:0]  pending;
   logic [15:0] absorbed;
   logic        absorbed_clr;

   // Second instance, GAP = 0
   logic [3:0]  g0_cell_state;
   logic [3:0]  g0_edge_word;
   logic        g0_mode;
   logic        g0_inj_valid;
   logic [7:0]  g0_inj_count;
   logic        g0_inj_ready;
   logic [7:0]  g0_pending;
   logic [15:0] g0_absorbed;
   logic        g0_absorbed_clr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] ew;
      logic [7:0] pend;
      string      tag;
   } exp_t;

   exp_t q_main[$];
   exp_t q_g0[$];

   lif_edge_port #(.IN_BIT(2), .OUT_BIT(0), .GAP(3)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .cell_state   (cell_state),
      .edge_word    (edge_word),
      .mode         (mode),
      .inj_valid    (inj_valid),
      .inj_count    (inj_count),
      .inj_ready    (inj_ready),
      .pending      (pending),
      .absorbed     (absorbed),
      .absorbed_clr (absorbed_clr)
   );

   lif_edge_port #(.IN_BIT(2), .OUT_BIT(0), .GAP(0)) u_g0 (
      .clk          (clk),
      .reset        (reset),
      .cell_state   (g0_cell_state),
      .edge_word    (g0_edge_word),
      .mode         (g0_mode),
      .inj_valid    (g0_inj_valid),
      .inj_count    (g0_inj_count),
      .inj_ready    (g0_inj_ready),
      .pending      (g0_pending),
      .absorbed     (g0_absorbed),
      .absorbed_clr (g0_absorbed_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Queue the expected post-edge state of the main DUT, clock once, then
   // pop and compare.
   task automatic step(input logic [3:0] ew, input logic [7:0] pend, input string tag);
      exp_t e;
      q_main.push_back('{ew, pend, tag});
      @(posedge clk);
      #1;
      e = q_main.pop_front();
      chk({e.tag, ".edge_word"}, {28'd0, edge_word}, {28'd0, e.ew});
      chk({e.tag, ".pending"},   {24'd0, pending},   {24'd0, e.pend});
      chk({e.tag, ".inj_ready"}, {31'd0, inj_ready}, {31'd0, (e.pend == 8'd0)});
   endtask

   task automatic step0(input logic [3:0] ew, input logic [7:0] pend, input string tag);
      exp_t e;
      q_g0.push_back('{ew, pend, tag});
      @(posedge clk);
      #1;
      e = q_g0.pop_front();
      chk({e.tag, ".edge_word"}, {28'd0, g0_edge_word}, {28'd0, e.ew});
      chk({e.tag, ".pending"},   {24'd0, g0_pending},   {24'd0, e.pend});
      chk({e.tag, ".inj_ready"}, {31'd0, g0_inj_ready}, {31'd0, (e.pend == 8'd0)});
   endtask

   initial begin
      reset = 1'b1;
      cell_state = 4'd0; mode = 1'b0; inj_valid = 1'b0; inj_count = 8'd0; absorbed_clr = 1'b0;
      g0_cell_state = 4'd0; g0_mode = 1'b0; g0_inj_valid = 1'b0; g0_inj_count = 8'd0; g0_absorbed_clr = 1'b0;

      // Reset state, before any clock edge
      #3;
      chk("rst.edge_word", {28'd0, edge_word}, 32'd0);
      chk("rst.pending",   {24'd0, pending},   32'd0);
      chk("rst.inj_ready", {31'd0, inj_ready}, 32'd1);
      chk("rst.absorbed",  {16'd0, absorbed},  32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // GAP = 0: back-to-back burst of 3
      g0_inj_valid = 1'b1; g0_inj_count = 8'd3;
      step0(4'b0000, 8'd3, "g0_acc");
      g0_inj_valid = 1'b0;
      step0(4'b0100, 8'd2, "g0_inj1");
      step0(4'b0100, 8'd1, "g0_inj2");
      step0(4'b0100, 8'd0, "g0_inj3");
      step0(4'b0000, 8'd0, "g0_idle");
      // Count of zero is accepted with no effect
      g0_inj_valid = 1'b1; g0_inj_count = 8'd0;
      step0(4'b0000, 8'd0, "g0_zero");
      g0_inj_valid = 1'b0;
      step0(4'b0000, 8'd0, "g0_zero_idle");

      // GAP = 3: two injections spaced four edges apart
      inj_valid = 1'b1; inj_count = 8'd2;
      step(4'b0000, 8'd2, "g3_acc");
      inj_valid = 1'b0;
      step(4'b0100, 8'd1, "g3_inj1");
      inj_valid = 1'b1; inj_count = 8'd9;     // not ready: must be ignored
      step(4'b0000, 8'd1, "g3_ignored");
      inj_valid = 1'b0;
      step(4'b0000, 8'd1, "g3_gap2");
      step(4'b0000, 8'd1, "g3_gap3");
      step(4'b0100, 8'd0, "g3_inj2");
      step(4'b0000, 8'd0, "g3_drain1");
      step(4'b0000, 8'd0, "g3_drain2");
      step(4'b0000, 8'd0, "g3_drain3");

      // Absorb: five separated outbound particles
      mode = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cell_state = 4'b0001;
         step(4'b0000, 8'd0, "abs_hit");
         chk("abs_count", {16'd0, absorbed}, 32'(i + 1));
         cell_state = 4'b0000;
         step(4'b0000, 8'd0, "abs_gap");
      end
      // Drive the counter to saturation
      cell_state = 4'b0001;
      repeat (65530) @(posedge clk);
      #1;
      chk("abs_full", {16'd0, absorbed}, 32'h0000FFFF);
      step(4'b0000, 8'd0, "abs_sat_step");
      chk("abs_sat", {16'd0, absorbed}, 32'h0000FFFF);
      // Clear wins over a coincident outbound particle
      absorbed_clr = 1'b1;
      step(4'b0000, 8'd0, "abs_clr_step");
      chk("abs_clr", {16'd0, absorbed}, 32'd0);
      absorbed_clr = 1'b0;
      cell_state = 4'b0000;
      step(4'b0000, 8'd0, "abs_after_clr");
      chk("abs_after_clr", {16'd0, absorbed}, 32'd0);

      // Reflect: one-hop bounce, not counted
      mode = 1'b1; cell_state = 4'b0001;
      step(4'b0100, 8'd0, "refl");
      chk("refl_abs", {16'd0, absorbed}, 32'd0);
      cell_state = 4'b0000;
      step(4'b0000, 8'd0, "refl_end");

      // Reflect stalls injection until the outbound stream stops
      cell_state = 4'b0001; inj_valid = 1'b1; inj_count = 8'd1;
      step(4'b0100, 8'd1, "stall_acc");
      inj_valid = 1'b0;
      step(4'b0100, 8'd1, "stall_r1");
      step(4'b0100, 8'd1, "stall_r2");
      cell_state = 4'b0000;
      step(4'b0100, 8'd0, "stall_inj");
      step(4'b0000, 8'd0, "stall_idle");
      chk("stall_abs", {16'd0, absorbed}, 32'd0);

      // Asynchronous reset in the middle of a burst
      mode = 1'b0; cell_state = 4'b0001;
      step(4'b0000, 8'd0, "pre_abs");
      chk("pre_abs", {16'd0, absorbed}, 32'd1);
      cell_state = 4'b0000;
      step(4'b0000, 8'd0, "pre_drain1");
      step(4'b0000, 8'd0, "pre_drain2");
      step(4'b0000, 8'd0, "pre_drain3");
      inj_valid = 1'b1; inj_count = 8'd5;
      step(4'b0000, 8'd5, "burst_acc");
      inj_valid = 1'b0;
      step(4'b0100, 8'd4, "burst_inj1");
      #2;
      reset = 1'b1;
      #1;
      chk("arst.edge_word", {28'd0, edge_word}, 32'd0);
      chk("arst.pending",   {24'd0, pending},   32'd0);
      chk("arst.inj_ready", {31'd0, inj_ready}, 32'd1);
      chk("arst.absorbed",  {16'd0, absorbed},  32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      step(4'b0000, 8'd0, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
